inst_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the fetch stage and `inst_memory`. Serves single-cycle hits to fetch. On a miss it stalls fetch, issues a block-read request over the ReadMiss/ReadReady handshake and installs the returned block. It then resumes. It forwards pipeline aborts so a wrong-path fill can be dropped early.

---
 rtl/inst_cache_pkg.sv | 25 ++
 rtl/inst_cache_array.sv | 48 ++++
 rtl/inst_cache.sv | 110 +++++++++++
 tb/tb_inst_cache.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding and
// address-field width helpers derived from the line and set counts.
package inst_cache_pkg;

   localparam int WORD_W = 32;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MISS = 1'b1
   } state_e;

   function automatic int offset_w(input int block_size);
      return $clog2(block_size);
   endfunction

   function automatic int index_w(input int num_sets);
      return $clog2(num_sets);
   endfunction

   // Byte-offset bits [1:0] are never part of offset, index or tag.
   function automatic int tag_w(input int block_size, input int num_sets);
      return 30 - offset_w(block_size) - index_w(num_sets);
   endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read port,
// synchronous whole-line write port, and a synchronous valid-clear on reset.
module inst_cache_array
   import inst_cache_pkg::*;
#(
   parameter int BLOCK_SIZE = 4,
   parameter int NUM_SETS   = 8
) (
   input  logic                                              clk_i,
   input  logic                                              rst_i,
   input  logic [index_w(NUM_SETS)-1:0]                      rd_idx_i,
   output logic                                              rd_valid_o,
   output logic [tag_w(BLOCK_SIZE, NUM_SETS)-1:0]            rd_tag_o,
   output logic [WORD_W*BLOCK_SIZE-1:0]                      rd_data_o,
   input  logic                                              wr_en_i,
   input  logic [index_w(NUM_SETS)-1:0]                      wr_idx_i,
   input  logic [tag_w(BLOCK_SIZE, NUM_SETS)-1:0]            wr_tag_i,
   input  logic [WORD_W*BLOCK_SIZE-1:0]                      wr_data_i
);

   localparam int TW = tag_w(BLOCK_SIZE, NUM_SETS);
   localparam int LW = WORD_W * BLOCK_SIZE;

   logic [NUM_SETS-1:0] valid_q;
   logic [TW-1:0]       tag_q  [NUM_SETS];
   logic [LW-1:0]       data_q [NUM_SETS];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // Tag and data carry no reset; a line is only trusted through its valid bit.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, a one-pulse
// block-read request on a miss, and early cancellation of wrong-path fills.
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int BLOCK_SIZE = 4,
   parameter int NUM_SETS   = 8
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic [31:0]                    PC,
   input  logic                           Fetch_en,
   input  logic                           Abort,
   output logic [31:0]                    Instr,
   output logic                           Hit,
   output logic                           Stall,
   output logic [31:0]                    Mem_Address,
   output logic                           ReadMiss,
   output logic                           Mem_abort,
   input  logic [WORD_W*BLOCK_SIZE-1:0]   Read_data,
   input  logic                           ReadReady
);

   localparam int OB = offset_w(BLOCK_SIZE);
   localparam int IW = index_w(NUM_SETS);
   localparam int TW = tag_w(BLOCK_SIZE, NUM_SETS);
   localparam logic [31:0] BLK_MASK = 32'(4 * BLOCK_SIZE - 1);

   state_e      state_q;
   logic [31:0] mem_addr_q;
   logic        read_miss_q;

   logic [OB-1:0]              pc_off;
   logic [IW-1:0]              pc_idx;
   logic [TW-1:0]              pc_tag;
   logic                       rd_valid;
   logic [TW-1:0]              rd_tag;
   logic [WORD_W*BLOCK_SIZE-1:0] rd_data;
   logic [31:0]                hit_word;
   logic                       lookup_hit;
   logic                       fill_en;
   logic                       unused_pc_bits;

   assign pc_off = PC[OB+1:2];
   assign pc_idx = PC[OB+IW+1:OB+2];
   assign pc_tag = PC[31:OB+IW+2];
   assign unused_pc_bits = &{1'b0, PC[1:0]};

   inst_cache_array #(
      .BLOCK_SIZE (BLOCK_SIZE),
      .NUM_SETS   (NUM_SETS)
   ) u_array (
      .clk_i      (Clk),
      .rst_i      (Rst),
      .rd_idx_i   (pc_idx),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .wr_en_i    (fill_en),
      .wr_idx_i   (mem_addr_q[OB+IW+1:OB+2]),
      .wr_tag_i   (mem_addr_q[31:OB+IW+2]),
      .wr_data_i  (Read_data)
   );

   always_comb begin
      hit_word = '0;
      for (int w = 0; w < BLOCK_SIZE; w++) begin
         if (pc_off == OB'(w)) begin
            hit_word = rd_data[WORD_W*w +: WORD_W];
         end
      end
   end

   // Lookups only count in IDLE; reset forces every fetch-side output low.
   assign lookup_hit = ~Rst & (state_q == S_IDLE) & Fetch_en & rd_valid & (rd_tag == pc_tag);
   assign Hit        = lookup_hit;
   assign Instr      = lookup_hit ? hit_word : 32'h0;
   assign Stall      = ~Rst & ((state_q == S_MISS) | (Fetch_en & ~lookup_hit));
   assign fill_en    = ~Rst & (state_q == S_MISS) & ReadReady;
   assign Mem_abort  = ~Rst & (state_q == S_MISS) & Abort & ~ReadReady;
   assign ReadMiss   = ~Rst & read_miss_q;
   assign Mem_Address = mem_addr_q;

   // A completing fill wins over a simultaneous abort.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= S_IDLE;
         mem_addr_q  <= '0;
         read_miss_q <= 1'b0;
      end else begin
         read_miss_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (Fetch_en & ~lookup_hit) begin
                  mem_addr_q  <= PC & ~BLK_MASK;
                  read_miss_q <= 1'b1;
                  state_q     <= S_MISS;
               end
            end
            S_MISS: begin
               if (ReadReady | Abort) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: cold miss, conflict eviction, aborts, reset
// during a miss, and idle fetch, with a 20-cycle memory driven inline.
module tb_inst_cache;

   localparam int BS = 4;
   localparam int NS = 8;

   logic          Clk = 1'b0;
   logic          Rst;
   logic [31:0]   PC;
   logic          Fetch_en;
   logic          Abort;
   logic [31:0]   Instr;
   logic          Hit;
   logic          Stall;
   logic [31:0]   Mem_Address;
   logic          ReadMiss;
   logic          Mem_abort;
   logic [32*BS-1:0] Read_data;
   logic          ReadReady;

   int errors = 0;
   int checks = 0;
   int rm_cnt;

   inst_cache #(.BLOCK_SIZE(BS), .NUM_SETS(NS)) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .PC          (PC),
      .Fetch_en    (Fetch_en),
      .Abort       (Abort),
      .Instr       (Instr),
      .Hit         (Hit),
      .Stall       (Stall),
      .Mem_Address (Mem_Address),
      .ReadMiss    (ReadMiss),
      .Mem_abort   (Mem_abort),
      .Read_data   (Read_data),
      .ReadReady   (ReadReady)
   );

   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Called in the first MISS cycle; ReadReady arrives 20 cycles after ReadMiss.
   task automatic do_fill(input logic [31:0] base, input logic abort_r, output int extra_rm);
      extra_rm = 0;
      for (int i = 0; i < 19; i++) begin
         tick();
         if (ReadMiss) extra_rm++;
      end
      tick();
      ReadReady = 1'b1;
      Abort     = abort_r;
      for (int k = 0; k < BS; k++) Read_data[32*k +: 32] = base + 32'(k);
      #1;
      chk("fill_stall", Stall, 1);
      chk("fill_mem_abort", Mem_abort, 0);
      tick();
      ReadReady = 1'b0;
      Abort     = 1'b0;
      Read_data = '0;
      #1;
   endtask

   initial begin
      Rst = 1'b1; PC = 32'h40; Fetch_en = 1'b1; Abort = 1'b0;
      ReadReady = 1'b0; Read_data = '0;
      tick();
      tick();
      chk("rst_hit", Hit, 0);
      chk("rst_stall", Stall, 0);
      chk("rst_readmiss", ReadMiss, 0);
      chk("rst_memabort", Mem_abort, 0);
      chk("rst_instr", Instr, 0);
      chk("rst_memaddr", Mem_Address, 0);

      // Cold miss on 0x40
      Rst = 1'b0;
      #1;
      chk("cold_hit", Hit, 0);
      chk("cold_stall", Stall, 1);
      chk("cold_rm_early", ReadMiss, 0);
      tick();
      chk("cold_readmiss", ReadMiss, 1);
      chk("cold_memaddr", Mem_Address, 32'h40);
      chk("cold_miss_stall", Stall, 1);
      chk("cold_miss_hit", Hit, 0);
      do_fill(32'hA0, 1'b0, rm_cnt);
      chk("cold_rm_once", rm_cnt, 0);
      chk("cold_refetch_hit", Hit, 1);
      chk("cold_refetch_instr", Instr, 32'hA0);
      chk("cold_refetch_stall", Stall, 0);
      PC = 32'h4C; #1;
      chk("word3_hit", Hit, 1);
      chk("word3_instr", Instr, 32'hA3);
      chk("word3_stall", Stall, 0);

      // Conflict on index 4
      PC = 32'hC0; #1;
      chk("conf_hit", Hit, 0);
      chk("conf_stall", Stall, 1);
      tick();
      chk("conf_readmiss", ReadMiss, 1);
      chk("conf_memaddr", Mem_Address, 32'hC0);
      do_fill(32'hC0, 1'b0, rm_cnt);
      chk("conf_rm_once", rm_cnt, 0);
      chk("conf_refetch_hit", Hit, 1);
      chk("conf_refetch_instr", Instr, 32'hC0);
      PC = 32'hC8; #1;
      chk("conf_word2_instr", Instr, 32'hC2);
      PC = 32'h40; #1;
      chk("evicted_hit", Hit, 0);
      chk("evicted_stall", Stall, 1);
      tick();
      chk("evicted_readmiss", ReadMiss, 1);
      chk("evicted_memaddr", Mem_Address, 32'h40);

      // Abort in the 5th MISS cycle
      for (int i = 0; i < 4; i++) tick();
      Abort = 1'b1; #1;
      chk("abort_memabort", Mem_abort, 1);
      chk("abort_stall", Stall, 1);
      tick();
      Abort = 1'b0; #1;
      chk("abort_idle_memabort", Mem_abort, 0);
      chk("abort_idle_hit", Hit, 0);
      chk("abort_idle_stall", Stall, 1);
      chk("abort_idle_rm", ReadMiss, 0);
      tick();
      chk("abort_reissue_rm", ReadMiss, 1);
      chk("abort_reissue_addr", Mem_Address, 32'h40);

      // Abort together with ReadReady: fill still lands
      do_fill(32'hA0, 1'b1, rm_cnt);
      chk("abrdy_rm_once", rm_cnt, 0);
      chk("abrdy_hit", Hit, 1);
      chk("abrdy_instr", Instr, 32'hA0);
      PC = 32'h44; #1;
      chk("abrdy_word1", Instr, 32'hA1);

      // Make 0xC0 resident, then reset during a miss on 0x100
      PC = 32'hC0; #1;
      tick();
      chk("pre_rst_rm", ReadMiss, 1);
      do_fill(32'hC0, 1'b0, rm_cnt);
      chk("pre_rst_hit", Hit, 1);
      PC = 32'h100; #1;
      chk("miss100_stall", Stall, 1);
      tick();
      chk("miss100_addr", Mem_Address, 32'h100);
      Rst = 1'b1; Abort = 1'b1; #1;
      chk("mrst_readmiss", ReadMiss, 0);
      chk("mrst_stall", Stall, 0);
      chk("mrst_hit", Hit, 0);
      chk("mrst_memabort", Mem_abort, 0);
      tick();
      Rst = 1'b0; Abort = 1'b0; PC = 32'hC0; #1;
      chk("mrst_memaddr", Mem_Address, 0);
      chk("mrst_c0_hit", Hit, 0);
      chk("mrst_c0_stall", Stall, 1);
      tick();
      chk("mrst_c0_rm", ReadMiss, 1);
      do_fill(32'hC0, 1'b0, rm_cnt);
      chk("mrst_c0_refill_hit", Hit, 1);

      // Fetch disabled with random PC
      Fetch_en = 1'b0;
      for (int i = 0; i < 50; i++) begin
         PC = $urandom; #1;
         chk("nofetch_outputs", {28'h0, Hit, Stall, ReadMiss, Mem_abort}, 32'h0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
